// File: rtl/tiger_uart_tx.sv
// tiger_uart_tx: FIFO-buffered UART transmitter producing 8N1 frames on txd.
// Define TIGER_UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module tiger_uart_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               txd,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic [2:0]                         state_dbg
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TW  = $clog2(DIV);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef TIGER_UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  // Handshake: a byte transfers on every rising edge where tx_valid && tx_ready;
  // tx_ready depends only on the registered count, never on tx_valid or a pop.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  assign tx_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shifter, shifter_n;
  logic          txd_n;
  logic          bit_end;

  assign bit_end   = (timer == TW'(DIV - 1));
  assign busy      = (state != IDLE) || (count != '0);
  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    timer_n   = timer + TW'(1);
    bit_idx_n = bit_idx;
    shifter_n = shifter;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (count != '0) begin
          pop       = 1'b1;
          shifter_n = mem[rd_ptr];
          state_n   = START;
        end
      end
      START: begin
        if (bit_end) begin
          timer_n   = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_n   = '0;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef TIGER_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef TIGER_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          timer_n = '0;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          timer_n = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (count != '0) begin
            pop       = 1'b1;
            shifter_n = mem[rd_ptr];
            state_n   = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is computed from the next state so the txd flop changes with the state.
    txd_n = 1'b1;
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shifter_n[bit_idx_n];
`ifdef TIGER_UART_TX_PARITY_EN
      PARITY:  txd_n = ^shifter_n;
`endif
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shifter <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      shifter <= shifter_n;
      txd     <= txd_n;
    end
  end
endmodule

// File: tb/tb_tiger_uart_tx.sv
// tb_tiger_uart_tx: randomized self-checking bench for tiger_uart_tx, with a line
// decoder that rebuilds frames from txd and compares them to the bytes pushed.
module tb_tiger_uart_tx;
  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 70;
  localparam int DEPTH  = 16;
  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef TIGER_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  // clock / reset / DUT
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic [4:0] fifo_count;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  tiger_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .busy(busy), .fifo_count(fifo_count),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // Expected line bits of one frame, index 0 = start bit.
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = b[i];
`ifdef TIGER_UART_TX_PARITY_EN
    f[9] = ($countones(b) % 2) == 1;
`endif
    return f;
  endfunction

  // scoreboard: line decoder sampling mid-bit on the falling clock edge
  bit            in_frame = 1'b0;
  bit            just_ended = 1'b0;
  int            pos = 0;
  int            frames_seen = 0;
  int            b2b_count = 0;
  logic [NB-1:0] line_bits;
  logic [NB-1:0] want_bits;
  logic [7:0]    want_byte;

  always @(negedge clk) begin
    if (reset) begin
      in_frame   = 1'b0;
      just_ended = 1'b0;
    end else begin
      if (!in_frame) begin
        if (txd === 1'b0) begin
          if (just_ended) b2b_count++;
          in_frame  = 1'b1;
          pos       = 0;
          line_bits = '0;
        end
        just_ended = 1'b0;
      end
      if (in_frame) begin
        if (pos % DIV == DIV / 2) line_bits[pos / DIV] = txd;
        if (pos == FRAME - 1) begin
          frames_seen++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL frame: got unexpected frame %b, want no frame", line_bits);
          end else begin
            want_byte = exp_q.pop_front();
            want_bits = frame_bits(want_byte);
            if (line_bits !== want_bits) begin
              n_errors++;
              $display("FAIL frame: got %b, want %b (byte %h)", line_bits, want_bits, want_byte);
            end
          end
          in_frame   = 1'b0;
          just_ended = 1'b1;
        end else begin
          pos++;
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL push_ready: got %b, want 1", tx_ready);
    end
    exp_q.push_back(b);
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((busy !== 1'b0 || in_frame) && t < 20 * FRAME) begin
      step();
      t++;
    end
    n_checks++;
    if (t >= 20 * FRAME) begin
      n_errors++;
      $display("FAIL %s_drain_timeout: busy=%b after %0d cycles, want 0", name, busy, t);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_pending: got %0d bytes not seen on line, want 0", name, exp_q.size());
    end
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1;
    repeat (5) step();
    reset = 1'b0;
    repeat (100) step();
    n_checks++;
    if (txd !== 1'b1) begin n_errors++; $display("FAIL reset_txd: got %b, want 1", txd); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b, want 1", tx_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
    n_checks++;
    if (fifo_count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d, want 0", fifo_count); end
  endtask

  task automatic test_single(input logic [7:0] b);
    push_one(b);
    n_checks++;
    if (fifo_count !== 5'd1 || txd !== 1'b1) begin
      n_errors++;
      $display("FAIL single_accept: got count=%0d txd=%b, want count=1 txd=1", fifo_count, txd);
    end
    step();
    n_checks++;
    if (fifo_count !== 5'd0 || txd !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL single_pop: got count=%0d txd=%b busy=%b, want 0 0 1", fifo_count, txd, busy);
    end
    repeat (FRAME - 1) step();
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_last: got %b, want 1", busy); end
    step();
    n_checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      n_errors++;
      $display("FAIL single_busy_fall: got busy=%b txd=%b, want 0 1", busy, txd);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL single_frame_seen: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    int nb;
    nb = $urandom_range(4, 8);
    for (int i = 0; i < nb; i++) begin
      push_one(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) step();
    end
    wait_drain("random");
  endtask

  task automatic test_simul();
    for (int i = 0; i < 4; i++) push_one(8'($urandom_range(0, 255)));
    n_checks++;
    if (fifo_count !== 5'd3) begin n_errors++; $display("FAIL simul_pre: got %0d, want 3", fifo_count); end
    repeat (FRAME - 3) step();
    n_checks++;
    if (fifo_count !== 5'd3) begin n_errors++; $display("FAIL simul_before_pop: got %0d, want 3", fifo_count); end
    push_one(8'($urandom_range(0, 255)));
    n_checks++;
    if (fifo_count !== 5'd3) begin n_errors++; $display("FAIL simul_pop_edge: got %0d, want 3", fifo_count); end
    step();
    n_checks++;
    if (fifo_count !== 5'd3) begin n_errors++; $display("FAIL simul_after: got %0d, want 3", fifo_count); end
    wait_drain("simul");
  endtask

  task automatic test_fill();
    int  model_cnt, idx, rel, accept_rel, b2b_before;
    bit  model_ready, do_push, do_pop;
    b2b_before = b2b_count;
    push_one(8'hEE);
    model_cnt  = 1;
    idx        = 0;
    rel        = 1;
    accept_rel = -1;
    while (idx < 17 && rel < 3 * FRAME) begin
      tx_data     = 8'(idx);
      tx_valid    = 1'b1;
      model_ready = (model_cnt != DEPTH);
      n_checks++;
      if (tx_ready !== model_ready) begin
        n_errors++;
        $display("FAIL fill_ready@%0d: got %b, want %b", rel, tx_ready, model_ready);
      end
      n_checks++;
      if (fifo_count !== 5'(model_cnt)) begin
        n_errors++;
        $display("FAIL fill_count@%0d: got %0d, want %0d", rel, fifo_count, model_cnt);
      end
      do_pop  = ((rel - 1) % FRAME == 0) && (model_cnt > 0);
      do_push = model_ready;
      if (do_push) begin
        exp_q.push_back(8'(idx));
        if (idx == 16) accept_rel = rel;
        idx++;
      end
      step();
      model_cnt = model_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      rel++;
    end
    tx_valid = 1'b0;
    n_checks++;
    if (accept_rel != FRAME + 2) begin
      n_errors++;
      $display("FAIL fill_last_accept: got edge %0d, want %0d", accept_rel, FRAME + 2);
    end
    n_checks++;
    if (fifo_count !== 5'd16) begin n_errors++; $display("FAIL fill_full: got %0d, want 16", fifo_count); end
    wait_drain("fill");
    n_checks++;
    if (b2b_count - b2b_before != 17) begin
      n_errors++;
      $display("FAIL fill_back_to_back: got %0d, want 17", b2b_count - b2b_before);
    end
  endtask

  task automatic test_reset_mid();
    int fs, low;
    push_one(8'hA5);
    push_one(8'($urandom_range(0, 255)));
    push_one(8'($urandom_range(0, 255)));
    repeat (4 * DIV + 2) step();
    #2;
    n_checks++;
    if (txd !== 1'b0) begin n_errors++; $display("FAIL rmid_bit3: got %b, want 0", txd); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (txd !== 1'b1) begin n_errors++; $display("FAIL rmid_txd: got %b, want 1", txd); end
    n_checks++;
    if (fifo_count !== 5'd0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rmid_state: got count=%0d busy=%b ready=%b, want 0 0 1", fifo_count, busy, tx_ready);
    end
    exp_q.delete();
    step();
    repeat (3) step();
    reset = 1'b0;
    fs  = frames_seen;
    low = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (txd !== 1'b1) low++;
    end
    n_checks++;
    if (low != 0 || frames_seen != fs || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rmid_silent: got low=%0d frames=%0d busy=%b, want 0 0 0", low, frames_seen - fs, busy);
    end
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, state_dbg=%0d", state_dbg);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_single(8'h55);
    test_single(8'($urandom_range(0, 255)));
    test_random();
    test_simul();
    test_fill();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
